// File: rtl/sub_serial_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_serial_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/Sub_full.sv
// One-bit combinational full subtractor: a - b - bin.
module Sub_full (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial LSB-first subtractor: one difference bit per cycle, result
// a - b - bin mod 2^WIDTH with final borrow-out.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
  logic             brw;
  logic [CW-1:0]    cnt;
  logic             bit_d, bit_b;
  logic             accept, last_bit;

  // A request is only honoured when no operation is in flight.
  assign accept   = start && (state != SHIFT);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  Sub_full u_full (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .bin (brw),
    .diff(bit_d),
    .bout(bit_b)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      a_sr    <= a;
      b_sr    <= b;
      diff_sr <= '0;
      brw     <= bin;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      diff_sr <= {bit_d, diff_sr[WIDTH-1:1]};
      brw     <= bit_b;
      cnt     <= cnt + CW'(1);
    end
  end

  // The borrow flop holds the running borrow, which after the last bit is bout.
  assign diff = diff_sr;
  assign bout = brw;

endmodule

// File: tb/tb_sub_serial.sv
// Scoreboard bench for sub_serial: stimulus pushes reference results, a
// negedge monitor pops and compares on every done pulse.
module tb_sub_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;

  int checks = 0;
  int bad = 0;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
  } exp_t;

  exp_t sb[$];

  sub_serial #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction, borrow when the true result is negative.
  function automatic exp_t model(input logic [W-1:0] ta, tb, input logic tbin);
    int   r;
    exp_t e;
    r      = int'(ta) - int'(tb) - int'(tbin);
    e.diff = r[W-1:0];
    e.bout = (r < 0);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb diff", 32'(diff), 32'(e.diff));
        check("sb bout", 32'(bout), 32'(e.bout));
      end
    end
  end

  // Drives one start cycle; returns 1 ns after the accepting edge.
  task automatic start_op(input logic [W-1:0] ta, tb, input logic tbin, input bit accepted);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(posedge clk);
    if (accepted) sb.push_back(model(ta, tb, tbin));
    #1 start = 1'b0;
  endtask

  // Returns at the negedge where done is high (i.e. still in DONE).
  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        cycles = i;
        return;
      end
    end
    check("done timeout", 32'(0), 32'(1));
  endtask

  initial begin
    int lat, busy_n, dn;
    logic [W-1:0] ra, rb;
    logic         rbin;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy), 32'(0));
    check("rst done", 32'(done), 32'(0));
    check("rst diff", 32'(diff), 32'(0));
    check("rst bout", 32'(bout), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // 5 - 3: busy for W cycles, done in cycle W+1 after start
    start_op(8'd5, 8'd3, 1'b0, 1);
    busy_n = 0; lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin lat = i; break; end
    end
    check("busy cycles", 32'(busy_n), 32'(W));
    check("done latency", 32'(lat), 32'(W + 1));
    repeat (3) @(negedge clk);
    check("hold diff", 32'(diff), 32'(8'h02));
    check("hold bout", 32'(bout), 32'(0));
    check("hold done", 32'(done), 32'(0));
    check("idle busy", 32'(busy), 32'(0));

    // Directed values, including both boundaries
    start_op(8'd3, 8'd5, 1'b0, 1);    wait_done(lat);
    start_op(8'h00, 8'h00, 1'b1, 1);  wait_done(lat);
    check("0-0-1 diff", 32'(diff), 32'(8'hFF));
    check("0-0-1 bout", 32'(bout), 32'(1));
    start_op(8'hFF, 8'hFF, 1'b0, 1);  wait_done(lat);
    check("ff-ff diff", 32'(diff), 32'(8'h00));
    check("ff-ff bout", 32'(bout), 32'(0));
    @(negedge clk);

    // Start while busy is ignored
    start_op(8'h80, 8'h01, 1'b0, 1);
    repeat (2) @(posedge clk);
    #1;
    start_op(8'h00, 8'hFF, 1'b0, 0);
    check("busy after ignored start", 32'(busy), 32'(1));
    wait_done(lat);
    check("ignored diff", 32'(diff), 32'(8'h7F));
    @(negedge clk);

    // Reset mid-operation aborts with no done pulse
    start_op(8'hA5, 8'h3C, 1'b1, 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'(0));
    check("abort diff", 32'(diff), 32'(0));
    check("abort done", 32'(done), 32'(0));
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("abort no done", 32'(dn), 32'(0));
    start_op(8'h33, 8'h44, 1'b0, 1);  wait_done(lat);
    check("post-reset latency", 32'(lat), 32'(W + 1));

    // Back-to-back: start driven during DONE
    start_op(8'h10, 8'h01, 1'b0, 1);
    wait_done(lat);
    check("b2b done spacing", 32'(lat), 32'(W + 1));
    check("b2b diff", 32'(diff), 32'(8'h0F));

    // Random operands, mixed back-to-back and idle gaps
    for (int n = 0; n < 200; n++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(ra, rb, rbin, 1);
      wait_done(lat);
    end
    repeat (3) @(negedge clk);
    check("sb drained", 32'(sb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
